// File: rtl/alfsr_pkg.sv
// Shared definitions for the ALFSR sequencer: controller state encoding and the
// default sizing constants used by the top level.
package alfsr_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StSettle,
        StRun
    } state_e;

    localparam int unsigned CFG_W_DEF   = 16;
    localparam int unsigned CLK_DIV_DEF = 4;
    localparam int unsigned SETTLE_DEF  = 32;
    localparam int unsigned SMP_DIV_DEF = 8;
    localparam int unsigned BYTE_W      = 8;

endpackage

// File: rtl/alfsr_ser_shift.sv
// Serial loader for the LFSR configurator.
// Shifts a CFG_W-bit word out MSB first. Each bit is presented on lfsr_dat_o while
// lfsr_clk_o is low for CLK_DIV cycles, then lfsr_clk_o is high for CLK_DIV cycles.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   load          capture cfg_word and begin shifting
//   abort         stop shifting immediately, outputs return low
//   cfg_word      word to shift out
//   lfsr_clk_o    configurator clock (registered, glitch-free)
//   lfsr_dat_o    configurator serial data (registered)
//   done          1-cycle pulse on the last cycle of the last bit
module alfsr_ser_shift #(
    parameter int unsigned CFG_W   = 16,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             abort,
    input  logic [CFG_W-1:0] cfg_word,
    output logic             lfsr_clk_o,
    output logic             lfsr_dat_o,
    output logic             done
);

    localparam int unsigned PhaseMax = 2 * CLK_DIV - 1;
    localparam int unsigned PhW      = $clog2(PhaseMax + 1);
    localparam int unsigned BitW     = (CFG_W > 1) ? $clog2(CFG_W) : 1;

    logic             active_q, active_d;
    logic [PhW-1:0]   phase_q, phase_d;
    logic [BitW-1:0]  bit_q, bit_d;
    logic [CFG_W-1:0] sreg_q, sreg_d;
    logic             clk_q, clk_d;
    logic             dat_q, dat_d;
    logic             last_phase, last_bit;

    assign last_phase = (phase_q == PhW'(PhaseMax));
    assign last_bit   = (bit_q == BitW'(CFG_W - 1));
    assign done       = active_q && last_phase && last_bit;
    assign lfsr_clk_o = clk_q;
    assign lfsr_dat_o = dat_q;

    always_comb begin
        active_d = active_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        sreg_d   = sreg_q;
        if (abort) begin
            active_d = 1'b0;
            phase_d  = '0;
            bit_d    = '0;
        end else if (load) begin
            active_d = 1'b1;
            phase_d  = '0;
            bit_d    = '0;
            sreg_d   = cfg_word;
        end else if (active_q) begin
            if (last_phase) begin
                phase_d = '0;
                if (last_bit) begin
                    active_d = 1'b0;
                    bit_d    = '0;
                end else begin
                    // Next bit appears while the clock is low.
                    bit_d  = bit_q + BitW'(1);
                    sreg_d = {sreg_q[CFG_W-2:0], 1'b0};
                end
            end else begin
                phase_d = phase_q + PhW'(1);
            end
        end
        // Pin outputs come straight from flops so the configurator clock cannot glitch.
        clk_d = active_d && (phase_d >= PhW'(CLK_DIV));
        dat_d = active_d && sreg_d[CFG_W-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            phase_q  <= '0;
            bit_q    <= '0;
            sreg_q   <= '0;
            clk_q    <= 1'b0;
            dat_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            sreg_q   <= sreg_d;
            clk_q    <= clk_d;
            dat_q    <= dat_d;
        end
    end

endmodule

// File: rtl/alfsr_seq_ctrl.sv
// Sequencer for the ALFSR core: serially configures the LFSR, holds the ALFSR in reset
// until configured, waits a settle time, then packs synchronized rng samples into bytes.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   start, stop       begin (IDLE only) / abort to IDLE; stop wins
//   cfg_word          configuration word, captured on an accepted start
//   lfsr_clk_o/dat_o  configurator serial interface
//   alfsr_rst_n       ALFSR reset, released in SETTLE and RUN
//   rng_bit_i         asynchronous digitized rng output
//   busy              high outside IDLE
//   byte_data/valid   packed byte (first sample in bit 7), valid held until byte_ready
//   byte_ready        consumer accept
//   ovf               sticky: a byte completed while the previous one was still pending
module alfsr_seq_ctrl
    import alfsr_pkg::*;
#(
    parameter int unsigned CFG_W   = CFG_W_DEF,
    parameter int unsigned CLK_DIV = CLK_DIV_DEF,
    parameter int unsigned SETTLE  = SETTLE_DEF,
    parameter int unsigned SMP_DIV = SMP_DIV_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [CFG_W-1:0]  cfg_word,
    output logic              lfsr_clk_o,
    output logic              lfsr_dat_o,
    output logic              alfsr_rst_n,
    input  logic              rng_bit_i,
    output logic              busy,
    output logic [BYTE_W-1:0] byte_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              ovf
);

    localparam int unsigned SetW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned SmpW = $clog2(SMP_DIV);

    state_e            state_q, state_d;
    logic [SetW-1:0]   settle_cnt_q;
    logic [SmpW-1:0]   smp_cnt_q;
    logic [1:0]        sync_q;
    logic [BYTE_W-1:0] acc_q;
    logic [2:0]        nbit_q;
    logic [BYTE_W-1:0] byte_data_q;
    logic              byte_valid_q;
    logic              ovf_q;

    logic              start_acc, shift_done, settle_last, smp_last;
    logic              sample, byte_done;
    logic [BYTE_W-1:0] new_byte;

    assign start_acc   = start && !stop && (state_q == StIdle);
    assign settle_last = (settle_cnt_q == SetW'(SETTLE - 1));
    assign smp_last    = (smp_cnt_q == SmpW'(SMP_DIV - 1));
    assign sample      = (state_q == StRun) && smp_last && !stop;
    assign byte_done   = sample && (nbit_q == 3'd7);
    assign new_byte    = {acc_q[BYTE_W-2:0], sync_q[1]};

    assign busy        = (state_q != StIdle);
    assign alfsr_rst_n = (state_q == StSettle) || (state_q == StRun);
    assign byte_data   = byte_data_q;
    assign byte_valid  = byte_valid_q;
    assign ovf         = ovf_q;

    alfsr_ser_shift #(
        .CFG_W   (CFG_W),
        .CLK_DIV (CLK_DIV)
    ) u_ser_shift (
        .clk        (clk),
        .rst        (rst),
        .load       (start_acc),
        .abort      (stop),
        .cfg_word   (cfg_word),
        .lfsr_clk_o (lfsr_clk_o),
        .lfsr_dat_o (lfsr_dat_o),
        .done       (shift_done)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start_acc) state_d = StShift;
            StShift:  if (shift_done) state_d = StSettle;
            StSettle: if (settle_last) state_d = StRun;
            StRun:    state_d = StRun;
            default:  state_d = StIdle;
        endcase
        if (stop) state_d = StIdle;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            settle_cnt_q <= '0;
            smp_cnt_q    <= '0;
            sync_q       <= '0;
            acc_q        <= '0;
            nbit_q       <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], rng_bit_i};

            // Counters only run in their own state, so nothing free-runs in IDLE.
            if ((state_q == StSettle) && !settle_last && !stop) begin
                settle_cnt_q <= settle_cnt_q + SetW'(1);
            end else begin
                settle_cnt_q <= '0;
            end

            if ((state_q == StRun) && !stop) begin
                smp_cnt_q <= smp_last ? '0 : smp_cnt_q + SmpW'(1);
            end else begin
                smp_cnt_q <= '0;
            end

            if ((state_q != StRun) || stop) begin
                acc_q  <= '0;
                nbit_q <= '0;
            end else if (sample) begin
                acc_q  <= new_byte;
                nbit_q <= nbit_q + 3'd1;
            end

            if (stop) begin
                byte_valid_q <= 1'b0;
            end else if (byte_done && (!byte_valid_q || byte_ready)) begin
                byte_data_q  <= new_byte;
                byte_valid_q <= 1'b1;
            end else if (byte_valid_q && byte_ready) begin
                byte_valid_q <= 1'b0;
            end

            if (start_acc) begin
                ovf_q <= 1'b0;
            end else if (byte_done && byte_valid_q && !byte_ready) begin
                ovf_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alfsr_seq_ctrl.sv
module tb_alfsr_seq_ctrl;

    localparam int CFG_W     = 16;
    localparam int CLK_DIV   = 4;
    localparam int SETTLE    = 32;
    localparam int SMP_DIV   = 8;
    localparam int SHIFT_LEN = CFG_W * 2 * CLK_DIV;
    localparam int RUN0      = SHIFT_LEN + SETTLE;
    localparam int BYTE_T    = 8 * SMP_DIV;

    logic             clk = 1'b0;
    logic             rst, start, stop, rng_bit_i, byte_ready;
    logic [CFG_W-1:0] cfg_word;
    logic             lfsr_clk_o, lfsr_dat_o, alfsr_rst_n, busy, byte_valid, ovf;
    logic [7:0]       byte_data;

    alfsr_seq_ctrl #(
        .CFG_W   (CFG_W),
        .CLK_DIV (CLK_DIV),
        .SETTLE  (SETTLE),
        .SMP_DIV (SMP_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .cfg_word    (cfg_word),
        .lfsr_clk_o  (lfsr_clk_o),
        .lfsr_dat_o  (lfsr_dat_o),
        .alfsr_rst_n (alfsr_rst_n),
        .rng_bit_i   (rng_bit_i),
        .busy        (busy),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         start_cyc = 0;
    int         rng_mode = 0;   // 0 random, 1 const one, 2 alternate per sample
    int         ready_mode = 0; // 0 low, 1 high, 2 random, 3 only on byte-completion cycles
    bit         rng_hist [0:65535];
    logic [7:0] exp_q [$];

    // Monitor-owned observations
    int         edge_cnt = 0;
    logic [15:0] captured = '0;
    logic [7:0] last_byte = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle counter plus rng / ready drivers, updated just after each rising edge.
    initial begin
        rng_bit_i  = 1'b0;
        byte_ready = 1'b0;
        forever begin
            int m;
            int t;
            bit r;
            @(posedge clk);
            cyc++;
            #1;
            t = cyc - start_cyc;
            m = t + 2 - RUN0;
            case (rng_mode)
                1:       r = 1'b1;
                2:       r = (m >= 0) && ((m / SMP_DIV) % 2 == 1);
                default: r = 1'($urandom_range(0, 1));
            endcase
            rng_bit_i = r;
            rng_hist[cyc] = r;
            case (ready_mode)
                1:       byte_ready = 1'b1;
                2:       byte_ready = 1'($urandom_range(0, 1));
                3:       byte_ready = (t > RUN0) && ((t - RUN0) % BYTE_T == 0);
                default: byte_ready = 1'b0;
            endcase
        end
    end

    // Reference model: timeline measured in cycles since the accepted start.
    initial begin
        bit         run_m = 0;
        int         t_m = 0;
        bit         vld_m = 0;
        bit         ovf_m = 0;
        logic [7:0] data_m = '0;
        logic [7:0] acc_m = '0;
        int         nsamp_m = 0;
        logic [15:0] cfg_m = '0;
        forever begin
            bit shifting, exp_clk, hs, loaded;
            int ph;
            @(negedge clk);
            shifting = run_m && (t_m >= 1) && (t_m <= SHIFT_LEN);
            ph = shifting ? (t_m - 1) % (2 * CLK_DIV) : 0;
            exp_clk = shifting && (ph >= CLK_DIV);
            check("busy", 32'(busy), 32'(run_m));
            check("alfsr_rst_n", 32'(alfsr_rst_n), 32'(run_m && (t_m > SHIFT_LEN)));
            check("byte_valid", 32'(byte_valid), 32'(vld_m));
            check("ovf", 32'(ovf), 32'(ovf_m));
            check("byte_data", 32'(byte_data), 32'(data_m));
            check("lfsr_clk", 32'(lfsr_clk_o), 32'(exp_clk));
            if (shifting) begin
                check("lfsr_dat", 32'(lfsr_dat_o),
                      32'(cfg_m[CFG_W - 1 - (t_m - 1) / (2 * CLK_DIV)]));
            end

            hs = vld_m && byte_ready;
            if (rst) begin
                run_m = 0; t_m = 0; vld_m = 0; ovf_m = 0; data_m = '0; nsamp_m = 0;
                if (!hs) exp_q.delete();
            end else if (stop) begin
                if (run_m) begin
                    run_m = 0; vld_m = 0; nsamp_m = 0;
                    if (!hs) exp_q.delete();
                end
            end else if (!run_m && start) begin
                run_m = 1; t_m = 1; ovf_m = 0; nsamp_m = 0; cfg_m = cfg_word;
            end else if (run_m) begin
                loaded = 0;
                if (t_m > RUN0 && ((t_m - RUN0) % SMP_DIV == 0)) begin
                    acc_m = {acc_m[6:0], rng_hist[cyc - 2]};
                    nsamp_m++;
                    if (nsamp_m == 8) begin
                        nsamp_m = 0;
                        if (!vld_m || byte_ready) begin
                            data_m = acc_m;
                            vld_m = 1;
                            loaded = 1;
                            exp_q.push_back(acc_m);
                        end else begin
                            ovf_m = 1;
                        end
                    end
                end
                if (hs && !loaded) vld_m = 0;
                t_m++;
            end
        end
    end

    // Monitor: pops the expected byte on every transfer, tracks hold stability and
    // captures configurator bits on each lfsr_clk rising edge.
    initial begin
        logic       prev_clk = 1'b0;
        logic       prev_hold = 1'b0;
        logic [7:0] prev_data = '0;
        forever begin
            @(negedge clk);
            if (prev_hold && byte_valid === 1'b1) begin
                check("byte_hold_stable", 32'(byte_data), 32'(prev_data));
            end
            if (byte_valid === 1'b1 && byte_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL byte_xfer: got %h expected no byte (cycle %0d)", byte_data, cyc);
                end else begin
                    check("byte_xfer", 32'(byte_data), 32'(exp_q.pop_front()));
                    last_byte = byte_data;
                end
            end
            if (lfsr_clk_o === 1'b1 && !prev_clk) begin
                captured = {captured[14:0], lfsr_dat_o};
                edge_cnt++;
            end
            prev_clk  = (lfsr_clk_o === 1'b1);
            prev_hold = (byte_valid === 1'b1) && !byte_ready;
            prev_data = byte_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic go(input logic [15:0] cfg);
        cfg_word = cfg;
        start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        bit seen;
        rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_word = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_rstn", 32'(alfsr_rst_n), 0);
        check("rst_lfsr_dat", 32'(lfsr_dat_o), 0);

        // Configuration shift, then random bytes with a random consumer.
        rng_mode = 0; ready_mode = 2;
        e0 = edge_cnt;
        go(16'hA5C3);
        repeat (SHIFT_LEN + 2) tick();
        check("shift_edges", 32'(edge_cnt - e0), 16);
        check("shift_word", 32'(captured), 32'h0000_A5C3);
        repeat (SETTLE + 5 * BYTE_T) tick();
        do_stop();

        // Constant one, then alternating pattern, consumer always ready.
        rng_mode = 1; ready_mode = 1;
        go(16'h0F0F);
        repeat (RUN0 + 3 * BYTE_T + 4) tick();
        check("ones_byte", 32'(last_byte), 32'hFF);
        check("ones_ovf", 32'(ovf), 0);
        do_stop();
        rng_mode = 2;
        go(16'h1357);
        repeat (RUN0 + 2 * BYTE_T + 4) tick();
        check("alt_byte", 32'(last_byte), 32'hAA);
        check("alt_ovf", 32'(ovf), 0);
        do_stop();

        // Stalled consumer: overflow is sticky until the next accepted start.
        rng_mode = 0; ready_mode = 0;
        go(16'hBEEF);
        repeat (RUN0 + 2 * BYTE_T + 4) tick();
        check("stall_ovf", 32'(ovf), 1);
        ready_mode = 1;
        repeat (20) tick();
        check("stall_ovf_kept", 32'(ovf), 1);
        go(16'h2222);
        check("ignored_start_ovf", 32'(ovf), 1);
        do_stop();
        go(16'h3333);
        check("restart_clears_ovf", 32'(ovf), 0);
        do_stop();

        // Abort in the middle of bit 5, then start and stop together in IDLE.
        go(16'hFFFF);
        repeat (2 * CLK_DIV * 5 + CLK_DIV - 1) tick();
        do_stop();
        check("abort_busy", 32'(busy), 0);
        check("abort_lfsr_clk", 32'(lfsr_clk_o), 0);
        check("abort_rstn", 32'(alfsr_rst_n), 0);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        tick();
        check("start_stop_idle", 32'(busy), 0);

        // start in RUN is ignored; reset while a byte is pending.
        ready_mode = 2;
        go(16'hC0DE);
        repeat (RUN0 + 70) tick();
        go(16'h1234);
        check("run_start_busy", 32'(busy), 1);
        repeat (3 * BYTE_T) tick();
        ready_mode = 0;
        tick();
        tick();
        seen = 0;
        for (int i = 0; i < 2 * BYTE_T && !seen; i++) begin
            if (byte_valid === 1'b1) seen = 1;
            else tick();
        end
        check("pending_before_rst", 32'(seen), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_run_busy", 32'(busy), 0);
        check("rst_run_valid", 32'(byte_valid), 0);
        check("rst_run_data", 32'(byte_data), 0);
        check("rst_run_ovf", 32'(ovf), 0);
        check("rst_run_rstn", 32'(alfsr_rst_n), 0);
        check("rst_run_lclk", 32'(lfsr_clk_o), 0);
        check("rst_run_ldat", 32'(lfsr_dat_o), 0);

        // Consumer accepts exactly when the next byte completes.
        rng_mode = 0; ready_mode = 3;
        go(16'h5A5A);
        repeat (RUN0 + 4 * BYTE_T + 3) tick();
        check("same_cycle_ovf", 32'(ovf), 0);
        check("same_cycle_valid", 32'(byte_valid), 1);
        do_stop();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
